pc_fetch_ctrl: RTL and testbench

//  Program-counter register and instruction-fetch sequencer for BIP-2.

---
 rtl/pc_fetch_ctrl.sv | 114 +++++++++++
 tb/tb_pc_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - BIP-2 program counter and instruction-fetch sequencer (optional PC_OVF_TRAP_EN)
// Sequence: IDLE -> FETCH (ROM req/ack) -> ISSUE (decoder valid/ready) -> FETCH ...

module pc_fetch_ctrl #(
    parameter int MSB_ROM  = 11,
    parameter int LSB      = 0,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [MSB_ROM-1:LSB]   pc_next_i,
    input  logic                   stall_i,
    output logic [MSB_ROM-1:LSB]   pc_o,
    output logic [MSB_ROM-1:LSB]   rom_addr_o,
    output logic                   rom_req_o,
    input  logic                   rom_ack_i,
    input  logic [INSTR_W-1:0]     rom_data_i,
    output logic [INSTR_W-1:0]     instr_o,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic                   trap_o
);

    localparam int PC_W = MSB_ROM - LSB;

`ifdef PC_OVF_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE} state_t;
`endif

    state_t              state;
    logic [MSB_ROM-1:LSB] pc_q;
    logic                accept;
    logic                wrap;

    assign pc_o       = pc_q;
    assign rom_addr_o = pc_q;

    // The decoder takes the instruction only when the pipeline is not stalled.
    assign accept = (state == S_ISSUE) && instr_ready_i && !stall_i;
    assign wrap   = (&pc_q) && (pc_next_i == '0);

`ifdef PC_OVF_TRAP_EN
    logic trap_q;
    assign trap_o = trap_q;
`else
    assign trap_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            pc_q          <= PC_W'(RESET_PC);
            rom_req_o     <= 1'b0;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
`ifdef PC_OVF_TRAP_EN
            trap_q        <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_FETCH;
                    rom_req_o <= 1'b1;
                end
                S_FETCH: begin
                    if (rom_ack_i) begin
                        instr_o       <= rom_data_i;
                        instr_valid_o <= 1'b1;
                        rom_req_o     <= 1'b0;
                        state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        instr_valid_o <= 1'b0;
`ifdef PC_OVF_TRAP_EN
                        if (wrap) begin
                            trap_q <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc_q      <= pc_next_i;
                            rom_req_o <= 1'b1;
                            state     <= S_FETCH;
                        end
`else
                        // A wrap simply loads zero and keeps fetching.
                        pc_q      <= pc_next_i;
                        rom_req_o <= 1'b1;
                        state     <= S_FETCH;
`endif
                    end
                end
`ifdef PC_OVF_TRAP_EN
                S_HALT: begin
                    rom_req_o     <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
`endif
                default: begin
                    state         <= S_IDLE;
                    rom_req_o     <= 1'b0;
                    instr_valid_o <= 1'b0;
                end
            endcase
        end
    end

    logic unused_wrap;
    assign unused_wrap = wrap;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - scoreboard bench for pc_fetch_ctrl (both PC_OVF_TRAP_EN builds)

module tb_pc_fetch_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [10:0] pc_next_i = '0;
    logic        stall_i = 1'b0;
    logic [10:0] pc_o;
    logic [10:0] rom_addr_o;
    logic        rom_req_o;
    logic        rom_ack_i = 1'b0;
    logic [15:0] rom_data_i = 16'hDEAD;
    logic [15:0] instr_o;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        trap_o;

    pc_fetch_ctrl #(.MSB_ROM(11), .LSB(0), .INSTR_W(16), .RESET_PC(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_next_i(pc_next_i), .stall_i(stall_i),
        .pc_o(pc_o), .rom_addr_o(rom_addr_o), .rom_req_o(rom_req_o),
        .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i), .instr_o(instr_o),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .trap_o(trap_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [10:0] pc;
        logic [15:0] instr;
        int          gap;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rom_delay = 0;
    int   req_len = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic logic [15:0] rom_f(input logic [10:0] a);
        return 16'hA000 | {5'b0, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ROM model: acknowledges after rom_delay wait cycles, checks address stays put.
    initial begin
        int          cnt;
        logic [10:0] addr0;
        cnt = 0;
        addr0 = '0;
        forever begin
            @(negedge clk_i);
            if (rom_req_o && !rst_i) begin
                if (cnt == 0) addr0 = rom_addr_o;
                else chk("rom_addr_stable", rom_addr_o, addr0);
                if (cnt >= rom_delay) begin
                    rom_ack_i  = 1'b1;
                    rom_data_i = rom_f(rom_addr_o);
                    req_len    = cnt + 1;
                    cnt        = 0;
                end else begin
                    rom_ack_i  = 1'b0;
                    rom_data_i = 16'hDEAD;
                    cnt++;
                end
            end else begin
                rom_ack_i  = 1'b0;
                rom_data_i = 16'hDEAD;
                cnt        = 0;
            end
        end
    end

    // Monitor: every decoder acceptance pops one expected instruction.
    initial begin
        int   last_acc;
        exp_t e;
        last_acc = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_i && instr_valid_o && instr_ready_i && !stall_i) begin
                if (q.size() == 0) begin
                    chk("unexpected_issue", 32'(pc_o), 32'h7FFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk("issue_pc", 32'(pc_o), 32'(e.pc));
                    chk("issue_instr", 32'(instr_o), 32'(e.instr));
                    if (e.gap != 0) chk("issue_gap", 32'(cyc - last_acc), 32'(e.gap));
                end
                last_acc = cyc;
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk_i);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_valid();
        int n;
        n = 0;
        while (!instr_valid_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!instr_valid_o) chk("valid_timeout", 32'(instr_valid_o), 32'd1);
    endtask

    task automatic issue(input logic [10:0] pc, input logic [10:0] nxt, input int gap);
        exp_t e;
        e.pc = pc; e.instr = rom_f(pc); e.gap = gap;
        q.push_back(e);
        wait_valid();
        pc_next_i = nxt; instr_ready_i = 1'b1; stall_i = 1'b0;
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
    endtask

    task automatic issue_bp(input logic [10:0] pc, input logic [10:0] nxt, input int gap);
        exp_t e;
        e.pc = pc; e.instr = rom_f(pc); e.gap = gap;
        q.push_back(e);
        wait_valid();
        pc_next_i = nxt;
        for (int i = 0; i < 7; i++) begin
            instr_ready_i = (i >= 5);
            stall_i       = (i >= 5);
            @(posedge clk_i); #1;
            chk("bp_valid", 32'(instr_valid_o), 32'd1);
            chk("bp_instr", 32'(instr_o), 32'(rom_f(pc)));
            chk("bp_pc", 32'(pc_o), 32'(pc));
        end
        stall_i = 1'b0; instr_ready_i = 1'b1;
        @(posedge clk_i); #1;
        instr_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_pc", 32'(pc_o), 32'd0);
        chk("rst_req", 32'(rom_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", 32'(instr_o), 32'd0);
        chk("rst_trap", 32'(trap_o), 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        rom_delay = 0;
        do_reset();
        @(posedge clk_i); #1;
        chk("req_after_release", 32'(rom_req_o), 32'd1);

        // Zero-wait stream: one instruction every 2 cycles.
        issue(11'h000, 11'h001, 0);
        issue(11'h001, 11'h002, 2);
        issue(11'h002, 11'h003, 2);
        issue(11'h003, 11'h004, 2);

        // Three ROM wait states.
        rom_delay = 3;
        issue(11'h004, 11'h005, 5);
        chk("req_len_wait3", 32'(req_len), 32'd4);
        rom_delay = 0;

        // Back-pressure then branch to 0x123.
        issue_bp(11'h005, 11'h123, 9);
        issue(11'h123, 11'h7FF, 2);

        // PC wrap.
        issue(11'h7FF, 11'h000, 2);
`ifdef PC_OVF_TRAP_EN
        chk("wrap_trap", 32'(trap_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            chk("halt_req", 32'(rom_req_o), 32'd0);
            chk("halt_valid", 32'(instr_valid_o), 32'd0);
            chk("halt_pc", 32'(pc_o), 32'h7FF);
        end
`else
        chk("wrap_no_trap", 32'(trap_o), 32'd0);
        chk("wrap_addr", 32'(rom_addr_o), 32'd0);
        issue(11'h000, 11'h001, 2);
        chk("wrap_no_trap2", 32'(trap_o), 32'd0);
`endif

        // Reset in the middle of a long FETCH.
        do_reset();
        rom_delay = 10;
        repeat (3) @(posedge clk_i);
        #1;
        chk("midfetch_req", 32'(rom_req_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("midfetch_req_drop", 32'(rom_req_o), 32'd0);
        chk("midfetch_trap", 32'(trap_o), 32'd0);
        rst_i = 1'b0;
        rom_delay = 0;
        issue(11'h000, 11'h001, 0);

        repeat (3) @(posedge clk_i);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
